lcd_power_sequencer: RTL and testbench
======================================

# lcd_power_sequencer

Sequences LCD panel power-up and power-down around the pixel pipeline: drives panel reset, gates the timing generator (`video_en` into LcdDriver), and switches the backlight only after video has been stable for a set number of frames. It sits in `rgb_fpga` beside LcdDriver in the `pclk` domain, replacing the tied-off `lcd_reset` and `lcd_bl` assignments. `frame_tick` comes from the timing generator's frame start.

## Interface
Parameters:
- `RST_CYCLES`, 70000: cycles `lcd_reset_n` is held low after power-up is requested (min 1).
- `WAKE_CYCLES`, 700000: cycles from reset release to `video_en` (min 1).
- `SETTLE_FRAMES`, 2: `frame_tick` pulses with video running before the backlight turns on (min 1).
- `BL_OFF_FRAMES`, 1: `frame_tick` pulses with the backlight off before video stops (min 1).
- `STOP_CYCLES`, 70000: cycles from `video_en` fall to re-asserting reset (min 1).
- `PWM_W`, 8: brightness and PWM counter width.

Ports:
- `pclk` in 1: pixel clock; the only clock.
- `rst` in 1: synchronous reset, active-high.
- `power_req` in 1: level; 1 requests the panel on, 0 requests it off.
- `frame_tick` in 1: one-cycle pulse per frame from the timing generator.
- `brightness` in PWM_W: backlight duty; used only with `LCD_BL_PWM_EN`.
- `lcd_reset_n` out 1: panel reset, active-low.
- `video_en` out 1: enables the timing generator and pixel output.
- `lcd_bl` out 1: backlight enable or PWM.
- `ready` out 1: high only in state ON.

## Operation
- Moore FSM. States: OFF, RST, WAKE, VIDEO, ON, BLOFF, STOP.
- One down-counter is loaded on every state entry. Its width is `$clog2` of the largest cycle parameter plus 1.
- Outputs by state:
  - OFF, RST: `lcd_reset_n`=0, `video_en`=0.
  - WAKE: `lcd_reset_n`=1, `video_en`=0.
  - VIDEO, ON, BLOFF: `lcd_reset_n`=1, `video_en`=1.
  - STOP: `lcd_reset_n`=1, `video_en`=0.
  - Backlight is active in ON only.
- Transitions:
  - OFF→RST when `power_req`=1.
  - RST→WAKE after RST_CYCLES.
  - WAKE→VIDEO after WAKE_CYCLES.
  - VIDEO→ON after SETTLE_FRAMES ticks.
  - ON→BLOFF when `power_req`=0.
  - BLOFF→STOP after BL_OFF_FRAMES ticks.
  - STOP→OFF after STOP_CYCLES.
- Abort rules:
  - `power_req`=0 in RST or WAKE goes straight to OFF.
  - `power_req`=0 in VIDEO goes to STOP, since the backlight is not yet on.
- Shutdown (BLOFF, STOP) always completes. A `power_req` reassertion is acted on only from OFF, so the minimum off time is one cycle in OFF.
- `frame_tick` is counted only in VIDEO and BLOFF and is ignored elsewhere. A tick coinciding with `power_req`=0 in VIDEO is not counted; the abort wins.
- `rst` mid-operation puts the FSM in OFF and cuts the backlight and video immediately. This is an abrupt stop, not a sequenced one.

## Timing
- Reset values: `lcd_reset_n`=0, `video_en`=0, `lcd_bl`=0, `ready`=0, state OFF, PWM counter 0.
- Outputs are registered and decoded from the state register, so they change on the same edge the state changes.
- If `power_req` is first sampled high at edge N:
  - RST from edge N.
  - `lcd_reset_n` rises at N+RST_CYCLES.
  - `video_en` rises at N+RST_CYCLES+WAKE_CYCLES.
- The edge that samples the SETTLE_FRAMES-th tick enters ON: `ready`=1 and the backlight is enabled on that edge.
- If `power_req` is sampled low in ON at edge M:
  - `lcd_bl`=0 and `ready`=0 at M.
  - STOP on the edge sampling the BL_OFF_FRAMES-th tick.
  - OFF STOP_CYCLES later.

## Configuration
- `LCD_BL_PWM_EN` defined:
  - The PWM counter free-runs, wrapping at 2^PWM_W.
  - `brightness` is latched when the counter is 0.
  - `lcd_bl` = (ON && cnt < latched). Brightness 0 gives always off; brightness 2^PWM_W−1 gives (2^W−1)/2^W duty.
- Undefined: `lcd_bl` = (state==ON). `brightness` is ignored and no PWM logic is built.

## Structure
- Package `lcd_pwr_pkg`: state enum `lcd_pwr_state_t` and default parameter constants.
- Sub-module `lcd_bl_pwm`: PWM counter, brightness latch and compare, instantiated only under `LCD_BL_PWM_EN`.

## Test plan
Parameters for all scenarios: RST=4, WAKE=6, SETTLE=2, BLOFF=1, STOP=3, PWM_W=4.
- Power-up: `power_req`=1 at edge 10, ticks every 20 cycles → `lcd_reset_n` rises at 14; `video_en` at 20; `ready` and `lcd_bl` on the 2nd tick after 20; no tick before 20 is counted.
- Power-down from ON: drop `power_req` → `lcd_bl`=0 same edge; `video_en` falls on the next tick; `lcd_reset_n`=0 three cycles later.
- Abort in WAKE: drop `power_req` 2 cycles after reset release → OFF next edge; `lcd_reset_n`=0; `video_en` never rises.
- Reassert during BLOFF: pulse `power_req` low for 1 cycle while in ON → full shutdown to OFF, then restart and `lcd_reset_n` low again for 4 cycles.
- PWM (macro on): brightness=5 in ON → `lcd_bl` high 5 of every 16 cycles. Change to 12 mid-period → the new duty applies from the next counter wrap. Brightness 0 → constantly 0.
- `rst` in ON → all outputs 0 on the next edge; FSM in OFF.

Source files
------------

// File: rtl/lcd_power_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pwr_pkg
// Shared types and defaults for the LCD power sequencer.
//   lcd_pwr_state_t : sequencer FSM states
//   DEF_*           : default timing / width parameters
//   max_of()        : helper used to size the shared down-counter
// -----------------------------------------------------------------------------
package lcd_pwr_pkg;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_RST   = 3'd1,
        ST_WAKE  = 3'd2,
        ST_VIDEO = 3'd3,
        ST_ON    = 3'd4,
        ST_BLOFF = 3'd5,
        ST_STOP  = 3'd6
    } lcd_pwr_state_t;

    localparam int DEF_RST_CYCLES    = 70000;
    localparam int DEF_WAKE_CYCLES   = 700000;
    localparam int DEF_SETTLE_FRAMES = 2;
    localparam int DEF_BL_OFF_FRAMES = 1;
    localparam int DEF_STOP_CYCLES   = 70000;
    localparam int DEF_PWM_W         = 8;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_power_sequencer_if.sv
// -----------------------------------------------------------------------------
// lcd_power_sequencer_if
// Control/status bundle between the panel power sequencer and its environment.
//   power_req   : level, 1 = panel on requested
//   frame_tick  : one-cycle pulse per frame from the timing generator
//   brightness  : backlight duty (PWM build only)
//   lcd_reset_n : panel reset, active-low
//   video_en    : timing generator / pixel output enable
//   lcd_bl      : backlight enable or PWM
//   ready       : panel fully on
// Modports: master = environment side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface lcd_power_sequencer_if
    import lcd_pwr_pkg::*;
#(
    parameter int PWM_W = DEF_PWM_W
);
    logic             power_req;
    logic             frame_tick;
    logic [PWM_W-1:0] brightness;
    logic             lcd_reset_n;
    logic             video_en;
    logic             lcd_bl;
    logic             ready;

    modport master (
        output power_req, frame_tick, brightness,
        input  lcd_reset_n, video_en, lcd_bl, ready
    );

    modport slave (
        input  power_req, frame_tick, brightness,
        output lcd_reset_n, video_en, lcd_bl, ready
    );
endinterface

// File: rtl/lcd_bl_pwm.sv
// -----------------------------------------------------------------------------
// lcd_bl_pwm
// Backlight PWM: free-running counter, brightness latch, duty compare.
//   clk          : pixel clock
//   rst          : synchronous active-high reset (counter and latch to 0)
//   en_i         : backlight allowed (sequencer in ON)
//   brightness_i : requested duty, out of 2^PWM_W
//   pwm_o        : en_i && (counter < latched brightness)
// Used only when LCD_BL_PWM_EN is defined.
// -----------------------------------------------------------------------------
module lcd_bl_pwm #(
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [PWM_W-1:0] brightness_i,
    output logic             pwm_o
);
    logic [PWM_W-1:0] cnt_q;
    logic [PWM_W-1:0] cnt_d;
    logic [PWM_W-1:0] lat_q;
    logic [PWM_W-1:0] lat_d;

    always_comb begin
        cnt_d = cnt_q + PWM_W'(1);
        lat_d = lat_q;
        // Capture on the wrapping edge so the new value is already in place
        // for the whole period that starts at counter 0; a change mid-period
        // therefore takes effect only from the next wrap.
        if (cnt_q == '1) begin
            lat_d = brightness_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            lat_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            lat_q <= lat_d;
        end
    end

    assign pwm_o = en_i && (cnt_q < lat_q);

endmodule

// File: rtl/lcd_power_sequencer.sv
// -----------------------------------------------------------------------------
// lcd_power_sequencer
// Sequences LCD panel power-up / power-down: panel reset, video enable and
// backlight, each released only after the previous stage has settled.
//   pclk : pixel clock (only clock)
//   rst  : synchronous active-high reset; abrupt stop to OFF
//   bus  : lcd_power_sequencer_if.slave (power_req, frame_tick, brightness in;
//          lcd_reset_n, video_en, lcd_bl, ready out)
// Optional feature macro: LCD_BL_PWM_EN -- backlight driven by a PWM whose
// duty follows brightness; without it lcd_bl is simply high in ON.
// -----------------------------------------------------------------------------
module lcd_power_sequencer
    import lcd_pwr_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int WAKE_CYCLES   = DEF_WAKE_CYCLES,
    parameter int SETTLE_FRAMES = DEF_SETTLE_FRAMES,
    parameter int BL_OFF_FRAMES = DEF_BL_OFF_FRAMES,
    parameter int STOP_CYCLES   = DEF_STOP_CYCLES,
    parameter int PWM_W         = DEF_PWM_W
) (
    input  logic                  pclk,
    input  logic                  rst,
    lcd_power_sequencer_if.slave  bus
);
    // One shared down-counter serves both cycle and frame waits, so it is
    // sized for the largest of all the wait parameters.
    localparam int MAX_WAIT = max_of(max_of(max_of(RST_CYCLES, WAKE_CYCLES),
                                            max_of(STOP_CYCLES, SETTLE_FRAMES)),
                                     BL_OFF_FRAMES);
    localparam int CNT_W = $clog2(MAX_WAIT) + 1;

    // Loaded with N-1: the state is left on the edge that sees 0, i.e. after
    // exactly N cycles (or N counted ticks).
    localparam logic [CNT_W-1:0] RST_LD    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LD   = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_FRAMES - 1);
    localparam logic [CNT_W-1:0] BLOFF_LD  = CNT_W'(BL_OFF_FRAMES - 1);
    localparam logic [CNT_W-1:0] STOP_LD   = CNT_W'(STOP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    lcd_pwr_state_t   state_q;
    lcd_pwr_state_t   state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             cnt_zero;
    logic             req;
    logic             tick;
    logic             bl_en;

    assign req      = bus.power_req;
    assign tick     = bus.frame_tick;
    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_OFF: begin
                if (req) begin
                    state_d = ST_RST;
                    cnt_d   = RST_LD;
                end
            end
            ST_RST: begin
                if (!req) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end else if (cnt_zero) begin
                    state_d = ST_WAKE;
                    cnt_d   = WAKE_LD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_WAKE: begin
                if (!req) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end else if (cnt_zero) begin
                    state_d = ST_VIDEO;
                    cnt_d   = SETTLE_LD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_VIDEO: begin
                // Abort beats a coincident tick; backlight never came on,
                // so go straight to the video-stop wait.
                if (!req) begin
                    state_d = ST_STOP;
                    cnt_d   = STOP_LD;
                end else if (tick) begin
                    if (cnt_zero) begin
                        state_d = ST_ON;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            ST_ON: begin
                if (!req) begin
                    state_d = ST_BLOFF;
                    cnt_d   = BLOFF_LD;
                end
            end
            ST_BLOFF: begin
                // Shutdown runs to completion regardless of power_req.
                if (tick) begin
                    if (cnt_zero) begin
                        state_d = ST_STOP;
                        cnt_d   = STOP_LD;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            ST_STOP: begin
                if (cnt_zero) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end
        endcase
    end

    // Moore outputs decoded from the state register, so they move on the
    // same edge as the state.
    always_comb begin
        bus.lcd_reset_n = 1'b0;
        bus.video_en    = 1'b0;
        bus.ready       = 1'b0;
        bl_en           = 1'b0;
        case (state_q)
            ST_WAKE, ST_STOP: begin
                bus.lcd_reset_n = 1'b1;
            end
            ST_VIDEO, ST_BLOFF: begin
                bus.lcd_reset_n = 1'b1;
                bus.video_en    = 1'b1;
            end
            ST_ON: begin
                bus.lcd_reset_n = 1'b1;
                bus.video_en    = 1'b1;
                bus.ready       = 1'b1;
                bl_en           = 1'b1;
            end
            default: begin
                bus.lcd_reset_n = 1'b0;
            end
        endcase
    end

`ifdef LCD_BL_PWM_EN
    lcd_bl_pwm #(
        .PWM_W (PWM_W)
    ) u_bl_pwm (
        .clk          (pclk),
        .rst          (rst),
        .en_i         (bl_en),
        .brightness_i (bus.brightness),
        .pwm_o        (bus.lcd_bl)
    );
`else
    assign bus.lcd_bl = bl_en;
`endif

endmodule

// File: tb/tb_lcd_power_sequencer.sv
module tb_lcd_power_sequencer;

    localparam int RST_C    = 4;
    localparam int WAKE_C   = 6;
    localparam int SETTLE_F = 2;
    localparam int BLOFF_F  = 1;
    localparam int STOP_C   = 3;
    localparam int PW       = 4;
    localparam int PERIOD   = 1 << PW;

    // Reference phases (independent numbering from the design)
    localparam int P_OFF = 10, P_RST = 11, P_WAKE = 12, P_VIDEO = 13,
                   P_ON = 14, P_BLOFF = 15, P_STOP = 16;

    logic pclk = 1'b0;
    logic rst  = 1'b1;
    always #5 pclk = ~pclk;

    lcd_power_sequencer_if #(.PWM_W(PW)) bus ();

    lcd_power_sequencer #(
        .RST_CYCLES    (RST_C),
        .WAKE_CYCLES   (WAKE_C),
        .SETTLE_FRAMES (SETTLE_F),
        .BL_OFF_FRAMES (BLOFF_F),
        .STOP_CYCLES   (STOP_C),
        .PWM_W         (PW)
    ) dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int t = 0;              // index of the most recent clock edge
    int tick_period = 20;   // 0 = random ticks
    int video_rises = 0;

    // Reference model state: absolute deadlines, frame counts, PWM phase
    int m_phase    = P_OFF;
    int m_deadline = 0;
    int m_frames   = 0;
    int m_since    = 0;     // edges since last reset
    int m_lat      = 0;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s edge=%0d got=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit req, input bit tk,
                              input int bri);
        if (r) begin
            m_phase = P_OFF; m_since = 0; m_lat = 0; m_frames = 0;
            return;
        end
        m_since++;
        if (m_since % PERIOD == 0) m_lat = bri;
        case (m_phase)
            P_OFF:   if (req) begin m_phase = P_RST; m_deadline = t + RST_C; end
            P_RST:   if (!req) m_phase = P_OFF;
                     else if (t == m_deadline) begin
                         m_phase = P_WAKE; m_deadline = t + WAKE_C;
                     end
            P_WAKE:  if (!req) m_phase = P_OFF;
                     else if (t == m_deadline) begin
                         m_phase = P_VIDEO; m_frames = 0;
                     end
            P_VIDEO: if (!req) begin m_phase = P_STOP; m_deadline = t + STOP_C; end
                     else if (tk) begin
                         m_frames++;
                         if (m_frames == SETTLE_F) m_phase = P_ON;
                     end
            P_ON:    if (!req) begin m_phase = P_BLOFF; m_frames = 0; end
            P_BLOFF: if (tk) begin
                         m_frames++;
                         if (m_frames == BLOFF_F) begin
                             m_phase = P_STOP; m_deadline = t + STOP_C;
                         end
                     end
            P_STOP:  if (t == m_deadline) m_phase = P_OFF;
            default: m_phase = P_OFF;
        endcase
    endtask

    task automatic step();
        bit tk;
        bit prev_video;
        bit exp_bl;
        if (tick_period > 0) tk = ((t + 1) % tick_period == 0);
        else                 tk = ($urandom_range(0, 7) == 0);
        bus.frame_tick = tk;
        prev_video = bus.video_en;
        @(posedge pclk);
        t++;
        model_edge(rst, bus.power_req, tk, int'(bus.brightness));
        #1;
        if (!prev_video && bus.video_en === 1'b1) video_rises++;
`ifdef LCD_BL_PWM_EN
        exp_bl = (m_phase == P_ON) && ((m_since % PERIOD) < m_lat);
`else
        exp_bl = (m_phase == P_ON);
`endif
        check_val("lcd_reset_n", 32'(bus.lcd_reset_n),
                  32'(m_phase inside {P_WAKE, P_VIDEO, P_ON, P_BLOFF, P_STOP}));
        check_val("video_en", 32'(bus.video_en),
                  32'(m_phase inside {P_VIDEO, P_ON, P_BLOFF}));
        check_val("ready", 32'(bus.ready), 32'(m_phase == P_ON));
        check_val("lcd_bl", 32'(bus.lcd_bl), 32'(exp_bl));
    endtask

    initial begin
        int rises0;
        bus.power_req  = 1'b0;
        bus.frame_tick = 1'b0;
        bus.brightness = '0;

        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        $display("TXN reset          edge=%0d errors=%0d", t, errors);

        // Power-up with a tick every 20 cycles
        bus.power_req = 1'b1;
        repeat (90) step();
        $display("TXN power_up       edge=%0d errors=%0d", t, errors);

        // Backlight PWM duty sweep while ON
        bus.brightness = 4'd5;
        repeat (48) step();
        repeat (7) step();
        bus.brightness = 4'd12;
        repeat (41) step();
        bus.brightness = 4'd0;
        repeat (32) step();
        bus.brightness = 4'd15;
        repeat (32) step();
        $display("TXN pwm_sweep      edge=%0d errors=%0d", t, errors);

        // Power-down from ON
        bus.power_req = 1'b0;
        repeat (40) step();
        $display("TXN power_down     edge=%0d errors=%0d", t, errors);

        // Abort two cycles after reset release; video must never start
        rises0 = video_rises;
        bus.power_req = 1'b1;
        for (int i = 0; i < 20 && m_phase != P_WAKE; i++) step();
        repeat (2) step();
        bus.power_req = 1'b0;
        repeat (15) step();
        check_val("abort_no_video", 32'(video_rises - rises0), 32'd0);
        $display("TXN abort_wake     edge=%0d errors=%0d", t, errors);

        // One-cycle drop in ON: full shutdown then restart
        bus.power_req = 1'b1;
        repeat (60) step();
        bus.power_req = 1'b0;
        step();
        bus.power_req = 1'b1;
        repeat (100) step();
        $display("TXN blink_restart  edge=%0d errors=%0d", t, errors);

        // Abrupt reset while ON
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (30) step();
        $display("TXN rst_in_on      edge=%0d errors=%0d", t, errors);

        // Random traffic
        tick_period = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) bus.power_req = ~bus.power_req;
            if ($urandom_range(0, 63) == 0) bus.brightness = PW'($urandom);
            rst = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0;
        $display("TXN random         edge=%0d errors=%0d", t, errors);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
